// File: rtl/digi_ota_pkg.sv
// Shared types and constants for the digital OTA comparator array.
package digi_ota_pkg;

  typedef enum logic [1:0] {
    DEC_LOW  = 2'd0,
    DEC_HIGH = 2'd1,
    DEC_HOLD = 2'd2
  } dec_t;

  localparam logic MODE_FREE    = 1'b0;
  localparam logic MODE_SAMPLED = 1'b1;

  // Persistence counter only needs to reach FILT_TH-1.
  function automatic int fcnt_width(input int th);
    return (th > 1) ? $clog2(th) : 1;
  endfunction

  localparam int FILT_TH_DEFAULT = 4;
  localparam int FCNT_W_DEFAULT  = fcnt_width(FILT_TH_DEFAULT);

endpackage

// File: rtl/digi_ota_chan.sv
// One comparator channel: synchroniser, tie-hold decision, persistence filter,
// saturating flip-event counter.
module digi_ota_chan
  import digi_ota_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_TH     = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             eval,
  input  logic             cnt_clr,
  input  logic             vip,
  input  logic             vin,
  output logic             out,
  output logic             chg,
  output logic [CNT_W-1:0] cnt
);

  localparam int FW = fcnt_width(FILT_TH);
  localparam logic [FW-1:0] LAST = FW'(FILT_TH - 1);

  logic [SYNC_STAGES-1:0] sync_p, sync_n;
  logic [FW-1:0]          fcnt;
  dec_t                   dec;
  logic                   disagree;
  logic                   flip;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p <= '0;
      sync_n <= '0;
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], vip};
      sync_n <= {sync_n[SYNC_STAGES-2:0], vin};
    end
  end

  // NOTE: defaults first in combinational blocks so no path infers a latch.
  always_comb begin
    dec = DEC_HOLD;
    if (sync_p[SYNC_STAGES-1] && !sync_n[SYNC_STAGES-1])
      dec = DEC_HIGH;
    else if (!sync_p[SYNC_STAGES-1] && sync_n[SYNC_STAGES-1])
      dec = DEC_LOW;
  end

  assign disagree = ((dec == DEC_HIGH) && !out) || ((dec == DEC_LOW) && out);
  assign flip     = eval && disagree && (fcnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt <= '0;
      out  <= 1'b0;
      chg  <= 1'b0;
    end else begin
      chg <= 1'b0;
      if (eval) begin
        if (!disagree) begin
          fcnt <= '0;
        end else if (flip) begin
          out  <= ~out;
          chg  <= 1'b1;
          fcnt <= '0;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end
    end
  end

  // Clear beats a coincident flip; saturates instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (cnt_clr)
      cnt <= '0;
    else if (flip && (cnt != '1))
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/digi_ota_array.sv
// Multi-channel clocked comparator array: evaluation gating plus registered
// event-count readback around NCH independent channels.
module digi_ota_array
  import digi_ota_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_TH     = 4,
  parameter int CNT_W       = 8,
  localparam int SEL_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             mode,
  input  logic             sample_en,
  input  logic [NCH-1:0]   vip,
  input  logic [NCH-1:0]   vin,
  input  logic [SEL_W-1:0] cnt_sel,
  input  logic             cnt_clr,
  output logic [NCH-1:0]   out,
  output logic [NCH-1:0]   chg,
  output logic [CNT_W-1:0] evt_cnt
);

  logic             eval;
  logic [CNT_W-1:0] cnt [NCH];
  logic [CNT_W-1:0] sel_cnt;

  assign eval = ena && ((mode == MODE_FREE) || ((mode == MODE_SAMPLED) && sample_en));

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    digi_ota_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_TH    (FILT_TH),
      .CNT_W      (CNT_W)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .eval   (eval),
      .cnt_clr(cnt_clr),
      .vip    (vip[i]),
      .vin    (vin[i]),
      .out    (out[i]),
      .chg    (chg[i]),
      .cnt    (cnt[i])
    );
  end

  // Unmatched selects (>= NCH) fall through to zero.
  always_comb begin
    sel_cnt = '0;
    for (int i = 0; i < NCH; i++)
      if (cnt_sel == SEL_W'(i))
        sel_cnt = cnt[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      evt_cnt <= '0;
    else
      evt_cnt <= sel_cnt;
  end

endmodule

// File: tb/tb_digi_ota_array.sv
// Scoreboard bench for digi_ota_array: a behavioural model pushes the expected
// outputs per edge, a monitor pops and compares them on the falling edge.
module tb_digi_ota_array;

  localparam int NCH     = 4;
  localparam int SYNC    = 2;
  localparam int FILT_TH = 4;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             ena, mode, sample_en, cnt_clr;
  logic [NCH-1:0]   vip, vin;
  logic [1:0]       cnt_sel;
  logic [NCH-1:0]   out, chg;
  logic [CNT_W-1:0] evt_cnt;

  digi_ota_array #(.NCH(NCH), .SYNC_STAGES(SYNC), .FILT_TH(FILT_TH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .mode     (mode),
    .sample_en(sample_en),
    .vip      (vip),
    .vin      (vin),
    .cnt_sel  (cnt_sel),
    .cnt_clr  (cnt_clr),
    .out      (out),
    .chg      (chg),
    .evt_cnt  (evt_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NCH-1:0]   out;
    logic [NCH-1:0]   chg;
    logic [CNT_W-1:0] evt;
  } exp_t;

  typedef struct packed {
    logic [NCH-1:0] p;
    logic [NCH-1:0] n;
  } pair_t;

  int    vectors = 0;
  int    miscompares = 0;
  exp_t  sb [$];

  // Reference model: inputs reach the decision SYNC edges late; a flip needs
  // FILT_TH consecutive disagreeing evaluation samples.
  pair_t          pipe [$];
  logic [NCH-1:0] m_out;
  int             m_run [NCH];
  int             m_cnt [NCH];
  pair_t          d;
  exp_t           e;
  logic           ev, hi, lo;

  task automatic model_reset();
    pipe.delete();
    for (int j = 0; j < SYNC; j++) pipe.push_back('0);
    m_out = '0;
    for (int c = 0; c < NCH; c++) begin
      m_run[c] = 0;
      m_cnt[c] = 0;
    end
  endtask

  initial model_reset();

  always @(posedge clk) begin
    e = '0;
    if (rst) begin
      model_reset();
    end else begin
      d = pipe.pop_front();
      pipe.push_back('{p: vip, n: vin});
      ev = ena && (!mode || sample_en);
      e.evt = (int'(cnt_sel) < NCH) ? CNT_W'(m_cnt[cnt_sel]) : '0;
      for (int c = 0; c < NCH; c++) begin
        hi = d.p[c] && !d.n[c];
        lo = !d.p[c] && d.n[c];
        if (ev) begin
          if ((hi && !m_out[c]) || (lo && m_out[c])) begin
            m_run[c]++;
            if (m_run[c] == FILT_TH) begin
              m_out[c] = ~m_out[c];
              m_run[c] = 0;
              e.chg[c] = 1'b1;
            end
          end else begin
            m_run[c] = 0;
          end
        end
        if (cnt_clr) m_cnt[c] = 0;
        else if (e.chg[c] && m_cnt[c] < CNT_MAX) m_cnt[c]++;
      end
      e.out = m_out;
    end
    sb.push_back(e);
  end

  exp_t got;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      got = sb.pop_front();
      vectors++;
      if (out !== got.out || chg !== got.chg || evt_cnt !== got.evt) begin
        miscompares++;
        $display("FAIL scoreboard t=%0t out=%b/%b chg=%b/%b evt_cnt=%0d/%0d (got/exp)",
                 $time, out, got.out, chg, got.chg, evt_cnt, got.evt);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic rand_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(5) == 0) begin
          vip[c] = 1'($urandom_range(1));
          vin[c] = 1'($urandom_range(1));
        end
      ena       = ($urandom_range(7) != 0);
      mode      = ($urandom_range(3) == 0);
      sample_en = 1'($urandom_range(1));
      cnt_sel   = 2'($urandom_range(NCH - 1));
      cnt_clr   = ($urandom_range(40) == 0);
      tick();
    end
  endtask

  task automatic quiet();
    ena = 1'b1; mode = 1'b0; sample_en = 1'b0; cnt_clr = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; vip = '0; vin = '0; cnt_sel = '0;
    quiet();
    repeat (3) tick();
    check("reset_out", 32'(out), 0);
    rst = 1'b0;
    rand_cycles(200);

    // Asynchronous reset mid-run: outputs clear with no clock edge.
    quiet(); vip = '0; vin = '0; cnt_sel = '0;
    tick();
    #1 rst = 1'b1;
    #1;
    check("async_rst_out", 32'(out), 0);
    check("async_rst_chg", 32'(chg), 0);
    check("async_rst_evt", 32'(evt_cnt), 0);
    tick(); tick();
    rst = 1'b0; vip = 4'b0001; vin = '0;
    repeat (5) tick();
    check("ch0_before_edge6", 32'(out[0]), 0);
    tick();
    check("ch0_flip_edge6", 32'(out[0]), 1);
    check("ch0_chg_pulse", 32'(chg[0]), 1);
    tick();
    check("ch0_chg_one_cycle", 32'(chg[0]), 0);

    // Glitch rejection on ch1: 3-sample pulse ignored, 4-sample pulse flips.
    vip[1] = 1'b1; vin[1] = 1'b0;
    repeat (3) tick();
    vip[1] = 1'b1; vin[1] = 1'b1;
    repeat (8) tick();
    check("ch1_glitch_rejected", 32'(out[1]), 0);
    vip[1] = 1'b1; vin[1] = 1'b0;
    repeat (4) tick();
    vip[1] = 1'b0; vin[1] = 1'b0;
    repeat (8) tick();
    check("ch1_pulse4_flips", 32'(out[1]), 1);

    // Sampled mode on ch2: strobes land on edges 3,6,9,12.
    mode = 1'b1; sample_en = 1'b0; vip[2] = 1'b1; vin[2] = 1'b0;
    for (int k = 0; k < 14; k++) begin
      sample_en = (k % 3 == 2);
      tick();
      if (k == 10) check("ch2_no_early_flip", 32'(out[2]), 0);
      if (k == 11) check("ch2_flip_4th_strobe", 32'(out[2]), 1);
    end
    quiet();

    // Freeze mid-filter: two samples, ena low for 10 cycles, two more samples.
    vip[0] = 1'b0; vin[0] = 1'b1;
    repeat (4) tick();
    ena = 1'b0;
    repeat (10) tick();
    ena = 1'b1;
    tick();
    check("freeze_hold", 32'(out[0]), 1);
    tick();
    check("freeze_resume_flip", 32'(out[0]), 0);

    // Saturating counter on ch3, then clear coincident with a flip.
    cnt_sel = 2'd3;
    for (int n = 0; n < 300; n++) begin
      vip[3] = (n % 2 == 0); vin[3] = ~vip[3];
      repeat (5) tick();
    end
    tick(); tick();
    check("ch3_saturate", 32'(evt_cnt), CNT_MAX);
    vip[3] = 1'b1; vin[3] = 1'b0;
    repeat (5) tick();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("ch3_flip_on_clr", 32'(chg[3]), 1);
    tick();
    check("ch3_clr_wins", 32'(evt_cnt), 0);

    // All channels flip on the same edge.
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    vip = ~m_out; vin = m_out;
    repeat (6) tick();
    check("all_chg", 32'(chg), 32'hF);
    for (int s = 0; s < NCH; s++) begin
      cnt_sel = 2'(s);
      tick(); tick();
      check($sformatf("cnt_ch%0d", s), 32'(evt_cnt), 1);
    end

    rand_cycles(600);
    quiet();
    tick(); tick();
    check("sb_backlog", 32'(sb.size() > 1), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
